// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the execute-stage branch resolver.
//   brs_state_t  : resolver FSM states (IDLE, REDIRECT, FLUSH)
//   bht_ctr_t    : 2-bit saturating branch history counter
//   STRONG_NT .. STRONG_T : counter encodings, BHT_RESET is the reset value
//   PC_INCR      : sequential fetch increment
//   bht_next()   : saturating counter update helper
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brs_state_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t STRONG_NT = 2'd0;
    localparam bht_ctr_t WEAK_NT   = 2'd1;
    localparam bht_ctr_t WEAK_T    = 2'd2;
    localparam bht_ctr_t STRONG_T  = 2'd3;

    localparam bht_ctr_t BHT_RESET = WEAK_NT;

    localparam int PC_INCR = 4;

    // Saturating step toward taken or not-taken.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != STRONG_T) res = ctr + 2'd1;
        end else begin
            if (ctr != STRONG_NT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// ---------------------------------------------------------------------------
// branch_bht
// Branch history table of 2-bit saturating counters.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (all entries WEAK_NT)
//   i_rd_idx       : combinational read index
//   o_rd_taken     : MSB of the indexed counter (predict taken)
//   i_wr_en        : apply a saturating update this edge
//   i_wr_idx       : entry to update
//   i_wr_taken     : update direction (1 = increment, 0 = decrement)
// A read of the entry being written in the same cycle returns the old value.
// ---------------------------------------------------------------------------
module branch_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_t r_ctr [ENTRIES];

    assign o_rd_taken = r_ctr[i_rd_idx][1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= BHT_RESET;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= bht_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Execute-stage branch resolver with a 2-bit BHT and mispredict recovery.
// Optional macro: BRANCH_STATS_EN enables the saturating statistics counters;
// without it o_stat_* are tied to 0.
// Ports:
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_ex_valid / o_ex_ready  : execute handshake (ready only in IDLE)
//   i_ex_is_branch/is_jump   : conditional branch / unconditional jump
//   i_ex_alu_branch_mask     : inversion mask applied to i_ex_alu_cond
//   i_ex_alu_cond            : ALU condition flag
//   i_ex_pred_taken          : prediction used by fetch
//   i_ex_pc, i_ex_target     : instruction PC and branch target
//   o_redirect_valid/_pc, i_redirect_ready : registered redirect to fetch
//   o_flush_if, o_flush_id   : registered flushes, FLUSH_CYCLES long
//   i_lookup_pc/o_lookup_taken : fetch-side combinational prediction
//   o_stat_branches, o_stat_mispredicts : statistics
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_valid,
    output logic            o_ex_ready,
    input  logic            i_ex_is_branch,
    input  logic            i_ex_is_jump,
    input  logic            i_ex_alu_branch_mask,
    input  logic            i_ex_alu_cond,
    input  logic            i_ex_pred_taken,
    input  logic [PC_W-1:0] i_ex_pc,
    input  logic [PC_W-1:0] i_ex_target,
    output logic            o_redirect_valid,
    input  logic            i_redirect_ready,
    output logic [PC_W-1:0] o_redirect_pc,
    output logic            o_flush_if,
    output logic            o_flush_id,
    input  logic [PC_W-1:0] i_lookup_pc,
    output logic            o_lookup_taken,
    output logic [31:0]     o_stat_branches,
    output logic [31:0]     o_stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    brs_state_t      r_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic            r_redirect_valid;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_flush;

    logic w_is_ctl;
    logic w_accept;
    logic w_taken;
    logic w_mispredict;
    logic w_bht_upd;
    logic w_lookup_unused;

    assign o_ex_ready   = (r_state == IDLE);
    assign w_is_ctl     = i_ex_is_branch | i_ex_is_jump;
    assign w_accept     = i_ex_valid & o_ex_ready & w_is_ctl;
    assign w_taken      = i_ex_is_jump ? 1'b1 : (i_ex_alu_cond ^ i_ex_alu_branch_mask);
    assign w_mispredict = (w_taken != i_ex_pred_taken);
    // Jumps carry no direction history, so only pure conditional branches train.
    assign w_bht_upd    = w_accept & i_ex_is_branch & ~i_ex_is_jump;

    // Only the index bits of the fetch PC select a counter.
    assign w_lookup_unused = ^{i_lookup_pc[PC_W-1:2+IDX_W], i_lookup_pc[1:0]};

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_idx   (i_lookup_pc[2 +: IDX_W]),
        .o_rd_taken (o_lookup_taken),
        .i_wr_en    (w_bht_upd),
        .i_wr_idx   (i_ex_pc[2 +: IDX_W]),
        .i_wr_taken (w_taken)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= IDLE;
            r_flush_cnt      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_mispredict) begin
                        r_redirect_pc    <= w_taken ? i_ex_target : (i_ex_pc + PC_W'(PC_INCR));
                        r_redirect_valid <= 1'b1;
                        r_state          <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (i_redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_flush          <= 1'b1;
                        r_flush_cnt      <= CNT_W'(FLUSH_CYCLES);
                        r_state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The handshake edge already counts as the first flush cycle,
                    // so the flush drops when the counter would reach zero.
                    r_flush_cnt <= r_flush_cnt - CNT_W'(1);
                    if (r_flush_cnt == CNT_W'(1)) begin
                        r_flush <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush_if       = r_flush;
    assign o_flush_id       = r_flush;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept) begin
            if (r_stat_branches != 32'hFFFF_FFFF) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign o_stat_branches    = r_stat_branches;
    assign o_stat_mispredicts = r_stat_mispredicts;
`else
    assign o_stat_branches    = 32'd0;
    assign o_stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Self-checking bench for branch_resolve_unit: directed cases followed by
// randomized branch/jump traffic compared against a transaction-level model
// (integer BHT array plus expected redirect/flush sequence per instruction).
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_alu_branch_mask;
    logic        ex_alu_cond;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks;
    int errors;

    int mBht [16];
    int mBranches;
    int mMisp;

    branch_resolve_unit dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_ex_valid           (ex_valid),
        .o_ex_ready           (ex_ready),
        .i_ex_is_branch       (ex_is_branch),
        .i_ex_is_jump         (ex_is_jump),
        .i_ex_alu_branch_mask (ex_alu_branch_mask),
        .i_ex_alu_cond        (ex_alu_cond),
        .i_ex_pred_taken      (ex_pred_taken),
        .i_ex_pc              (ex_pc),
        .i_ex_target          (ex_target),
        .o_redirect_valid     (redirect_valid),
        .i_redirect_ready     (redirect_ready),
        .o_redirect_pc        (redirect_pc),
        .o_flush_if           (flush_if),
        .o_flush_id           (flush_id),
        .i_lookup_pc          (lookup_pc),
        .o_lookup_taken       (lookup_taken),
        .o_stat_branches      (stat_branches),
        .o_stat_mispredicts   (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int modelIdx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic logic [31:0] expStat(input int v);
`ifdef BRANCH_STATS_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mBht[i] = 1;
        mBranches = 0;
        mMisp     = 0;
    endtask

    task automatic checkLookup(input string tag, input logic [31:0] pc);
        lookup_pc = pc;
        #1;
        checkOutput(tag, {31'd0, lookup_taken}, {31'd0, mBht[modelIdx(pc)] >= 2});
    endtask

    task automatic checkStats(input string tag);
        checkOutput({tag, " branches"}, stat_branches, expStat(mBranches));
        checkOutput({tag, " mispredicts"}, stat_mispredicts, expStat(mMisp));
    endtask

    // Present one instruction at a negedge, let it be accepted, then follow
    // the whole expected recovery sequence. While recovery runs a different
    // branch is held on the execute port; it must not be accepted.
    task automatic applyStimulus(input logic isBr, input logic isJmp, input logic mask,
                                 input logic cond, input logic pred,
                                 input logic [31:0] pc, input logic [31:0] target,
                                 input int waitCycles, input logic abortInFlush);
        logic        isCtl;
        logic        taken;
        logic        misp;
        logic [31:0] expPc;
        int          idx;
        int          flushCount;
        isCtl = isBr | isJmp;
        taken = isJmp ? 1'b1 : (cond ^ mask);
        misp  = isCtl && (taken != pred);
        expPc = taken ? target : pc + 32'd4;
        idx   = modelIdx(pc);

        @(negedge clk);
        ex_valid           = 1'b1;
        ex_is_branch       = isBr;
        ex_is_jump         = isJmp;
        ex_alu_branch_mask = mask;
        ex_alu_cond        = cond;
        ex_pred_taken      = pred;
        ex_pc              = pc;
        ex_target          = target;
        checkLookup("lookup before accept", pc);
        checkOutput("ex_ready idle", {31'd0, ex_ready}, 32'd1);

        @(negedge clk);
        if (isCtl) begin
            mBranches++;
            if (misp) mMisp++;
            if (isBr && !isJmp) begin
                if (taken && mBht[idx] < 3) mBht[idx]++;
                if (!taken && mBht[idx] > 0) mBht[idx]--;
            end
        end

        if (!misp) begin
            ex_valid = 1'b0;
            checkOutput("no redirect", {31'd0, redirect_valid}, 32'd0);
            checkOutput("no flush", {31'd0, flush_if}, 32'd0);
            checkOutput("ex_ready no stall", {31'd0, ex_ready}, 32'd1);
            return;
        end

        ex_is_branch       = 1'b1;
        ex_is_jump         = 1'b0;
        ex_alu_cond        = 1'b1;
        ex_alu_branch_mask = 1'b0;
        ex_pred_taken      = 1'b0;
        ex_pc              = $urandom & 32'hFFFF_FFFC;

        checkOutput("redirect_valid rise", {31'd0, redirect_valid}, 32'd1);
        checkOutput("redirect_pc", redirect_pc, expPc);
        checkOutput("ex_ready redirect", {31'd0, ex_ready}, 32'd0);
        redirect_ready = 1'b0;
        for (int i = 0; i < waitCycles; i++) begin
            @(negedge clk);
            checkOutput("redirect_valid hold", {31'd0, redirect_valid}, 32'd1);
            checkOutput("redirect_pc hold", redirect_pc, expPc);
            checkOutput("ex_ready hold", {31'd0, ex_ready}, 32'd0);
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        checkOutput("redirect_valid drop", {31'd0, redirect_valid}, 32'd0);
        checkOutput("flush_if start", {31'd0, flush_if}, 32'd1);
        checkOutput("flush_id start", {31'd0, flush_id}, 32'd1);
        checkOutput("ex_ready flush", {31'd0, ex_ready}, 32'd0);

        if (abortInFlush) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n    = 1'b1;
            ex_valid = 1'b0;
            modelReset();
            checkOutput("abort redirect_valid", {31'd0, redirect_valid}, 32'd0);
            checkOutput("abort redirect_pc", redirect_pc, 32'd0);
            checkOutput("abort flush_if", {31'd0, flush_if}, 32'd0);
            checkOutput("abort flush_id", {31'd0, flush_id}, 32'd0);
            checkOutput("abort ex_ready", {31'd0, ex_ready}, 32'd1);
            checkLookup("abort bht", pc);
            checkStats("abort stats");
            return;
        end

        flushCount = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (flush_if) flushCount++;
            else break;
        end
        ex_valid = 1'b0;
        checkOutput("flush length", 32'(flushCount), 32'd2);
        checkOutput("flush_id end", {31'd0, flush_id}, 32'd0);
        checkOutput("ex_ready back", {31'd0, ex_ready}, 32'd1);
        checkOutput("redirect_valid idle", {31'd0, redirect_valid}, 32'd0);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        ex_valid           = 1'b0;
        ex_is_branch       = 1'b0;
        ex_is_jump         = 1'b0;
        ex_alu_branch_mask = 1'b0;
        ex_alu_cond        = 1'b0;
        ex_pred_taken      = 1'b0;
        ex_pc              = 32'd0;
        ex_target          = 32'd0;
        redirect_ready     = 1'b0;
        lookup_pc          = 32'd0;
        modelReset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("reset redirect_pc", redirect_pc, 32'd0);
        checkOutput("reset flush_if", {31'd0, flush_if}, 32'd0);
        checkOutput("reset ex_ready", {31'd0, ex_ready}, 32'd1);
        checkStats("reset stats");
        for (int i = 0; i < 4; i++) checkLookup("reset lookup", $urandom);

        // Directed cases
        applyStimulus(1, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0);
        checkLookup("bht 0x100 weak taken", 32'h0000_0100);
        applyStimulus(1, 0, 1, 1, 0, 32'h0000_0104, 32'h0000_0300, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 32'h0000_0108, 32'h0000_0300, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 32'h0000_0108, 32'h0000_0300, 0, 0);
        checkLookup("bht 0x108 taken", 32'h0000_0108);
        applyStimulus(1, 0, 0, 1, 1, 32'h0000_0108, 32'h0000_0300, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 32'h0000_010C, 32'h0000_0300, 3, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0000_0110, 32'h0000_0400, 1, 0);
        checkLookup("jump leaves bht", 32'h0000_0110);
        applyStimulus(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0500, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_0120, 32'h0000_0600, 0, 0);
        checkStats("directed stats");
        applyStimulus(1, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0700, 1, 1);

        // Five branches, two of them mispredicted, from a clean reset
        applyStimulus(1, 0, 0, 1, 1, 32'h0000_0200, 32'h0000_0800, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0000_0204, 32'h0000_0800, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 32'h0000_0208, 32'h0000_0800, 2, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'h0000_020C, 32'h0000_0900, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 32'h0000_0210, 32'h0000_0900, 0, 0);
        checkStats("five branches");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic        isBr;
            logic        isJmp;
            logic [31:0] pc;
            kind  = $urandom_range(0, 9);
            isJmp = (kind < 2);
            isBr  = (kind >= 3) || (kind == 0 && $urandom_range(0, 1) == 1);
            pc    = ($urandom & 32'h0000_00FC) | (($urandom & 32'h3) << 28);
            applyStimulus(isBr, isJmp, 1'($urandom), 1'($urandom), 1'($urandom),
                          pc, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), 1'b0);
            if ((n % 8) == 0) checkLookup("random lookup", $urandom);
        end
        checkStats("final stats");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
